// File: rtl/id_stage.sv
// RV32I decode stage with built-in IF/ID register.
// Resolves JAL here and squashes the single wrong-path fetch behind it.
module id_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_insn,
    input  logic            if_en,
    input  logic            stall,
    input  logic            flush,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_insn,
    output logic            id_en,
    output logic [4:0]      id_rs1_addr,
    output logic [4:0]      id_rs2_addr,
    output logic [4:0]      id_rd_addr,
    output logic [XLEN-1:0] id_imm,
    output logic [3:0]      id_alu_op,
    output logic [3:0]      id_mem_op,
    output logic            id_reg_we,
    output logic            id_is_branch,
    output logic            id_is_jal,
    output logic            id_is_jalr,
    output logic            id_illegal,
    output logic            id_br_taken,
    output logic [XLEN-1:0] id_br_addr
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;
    localparam logic [3:0] MEM_NONE = 4'd0, MEM_LB = 4'd1, MEM_LH = 4'd2, MEM_LW = 4'd3,
                           MEM_LBU = 4'd4, MEM_LHU = 4'd5, MEM_SB = 4'd6, MEM_SH = 4'd7,
                           MEM_SW = 4'd8;

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    assign w_opc   = if_insn[6:0];
    assign w_f3    = if_insn[14:12];
    assign w_f7    = if_insn[31:25];
    assign w_imm_i = {{20{if_insn[31]}}, if_insn[31:20]};
    assign w_imm_s = {{20{if_insn[31]}}, if_insn[31:25], if_insn[11:7]};
    assign w_imm_b = {{19{if_insn[31]}}, if_insn[31], if_insn[7], if_insn[30:25], if_insn[11:8], 1'b0};
    assign w_imm_u = {if_insn[31:12], 12'b0};
    assign w_imm_j = {{11{if_insn[31]}}, if_insn[31], if_insn[19:12], if_insn[20], if_insn[30:21], 1'b0};

    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [31:0] w_imm;
    logic [3:0]  w_alu, w_mem;
    logic        w_has_rd, w_br, w_jal, w_jalr, w_ill;

    always_comb begin
        w_rs1 = 5'd0; w_rs2 = 5'd0; w_rd = 5'd0; w_imm = 32'd0;
        w_alu = ALU_ADD; w_mem = MEM_NONE; w_has_rd = 1'b0;
        w_br = 1'b0; w_jal = 1'b0; w_jalr = 1'b0; w_ill = 1'b0;
        case (w_opc)
            7'b0110111: begin w_has_rd = 1'b1; w_imm = w_imm_u; w_alu = ALU_PASSB; end
            7'b0010111: begin w_has_rd = 1'b1; w_imm = w_imm_u; end
            7'b1101111: begin w_has_rd = 1'b1; w_imm = w_imm_j; w_jal = 1'b1; end
            7'b1100111: begin
                w_has_rd = 1'b1; w_rs1 = if_insn[19:15]; w_imm = w_imm_i; w_jalr = 1'b1;
                w_ill = (w_f3 != 3'b000);
            end
            7'b1100011: begin
                w_rs1 = if_insn[19:15]; w_rs2 = if_insn[24:20]; w_imm = w_imm_b; w_br = 1'b1;
                case (w_f3)
                    3'b000, 3'b001: w_alu = ALU_SUB;
                    3'b100, 3'b101: w_alu = ALU_SLT;
                    3'b110, 3'b111: w_alu = ALU_SLTU;
                    default:        w_ill = 1'b1;
                endcase
            end
            7'b0000011: begin
                w_has_rd = 1'b1; w_rs1 = if_insn[19:15]; w_imm = w_imm_i;
                case (w_f3)
                    3'b000:  w_mem = MEM_LB;
                    3'b001:  w_mem = MEM_LH;
                    3'b010:  w_mem = MEM_LW;
                    3'b100:  w_mem = MEM_LBU;
                    3'b101:  w_mem = MEM_LHU;
                    default: w_ill = 1'b1;
                endcase
            end
            7'b0100011: begin
                w_rs1 = if_insn[19:15]; w_rs2 = if_insn[24:20]; w_imm = w_imm_s;
                case (w_f3)
                    3'b000:  w_mem = MEM_SB;
                    3'b001:  w_mem = MEM_SH;
                    3'b010:  w_mem = MEM_SW;
                    default: w_ill = 1'b1;
                endcase
            end
            7'b0010011: begin
                w_has_rd = 1'b1; w_rs1 = if_insn[19:15]; w_imm = w_imm_i;
                case (w_f3)
                    3'b000: w_alu = ALU_ADD;
                    3'b001: begin w_alu = ALU_SLL; w_ill = (w_f7 != 7'h00); end
                    3'b010: w_alu = ALU_SLT;
                    3'b011: w_alu = ALU_SLTU;
                    3'b100: w_alu = ALU_XOR;
                    3'b101: begin
                        w_alu = if_insn[30] ? ALU_SRA : ALU_SRL;
                        w_ill = (w_f7 != 7'h00) && (w_f7 != 7'h20);
                    end
                    3'b110: w_alu = ALU_OR;
                    default: w_alu = ALU_AND;
                endcase
            end
            7'b0110011: begin
                w_has_rd = 1'b1; w_rs1 = if_insn[19:15]; w_rs2 = if_insn[24:20];
                case (w_f3)
                    3'b000: w_alu = if_insn[30] ? ALU_SUB : ALU_ADD;
                    3'b001: w_alu = ALU_SLL;
                    3'b010: w_alu = ALU_SLT;
                    3'b011: w_alu = ALU_SLTU;
                    3'b100: w_alu = ALU_XOR;
                    3'b101: w_alu = if_insn[30] ? ALU_SRA : ALU_SRL;
                    3'b110: w_alu = ALU_OR;
                    default: w_alu = ALU_AND;
                endcase
                // funct7 0x20 only exists for SUB and SRA
                w_ill = ((w_f7 != 7'h00) && (w_f7 != 7'h20)) ||
                        ((w_f7 == 7'h20) && (w_f3 != 3'b000) && (w_f3 != 3'b101));
            end
            7'b0001111: w_ill = (w_f3 != 3'b000);
            default:    w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_rs1 = 5'd0; w_rs2 = 5'd0; w_rd = 5'd0; w_imm = 32'd0;
            w_alu = ALU_ADD; w_mem = MEM_NONE; w_has_rd = 1'b0;
            w_br = 1'b0; w_jal = 1'b0; w_jalr = 1'b0;
        end else if (w_has_rd) begin
            w_rd = if_insn[11:7];
        end
    end

    logic [XLEN-1:0] r_pc, r_imm;
    logic [31:0]     r_insn;
    logic            r_en, r_we, r_br, r_jal, r_jalr, r_ill;
    logic [4:0]      r_rs1, r_rs2, r_rd;
    logic [3:0]      r_alu, r_mem;
    logic            w_br_taken;

    assign w_br_taken = r_en & r_jal & ~stall & ~flush;

    always_ff @(posedge clk) begin
        if (reset || flush || (!stall && (w_br_taken || !if_en))) begin
            r_pc <= '0; r_insn <= NOP; r_en <= 1'b0;
            r_rs1 <= 5'd0; r_rs2 <= 5'd0; r_rd <= 5'd0; r_imm <= '0;
            r_alu <= ALU_ADD; r_mem <= MEM_NONE; r_we <= 1'b0;
            r_br <= 1'b0; r_jal <= 1'b0; r_jalr <= 1'b0; r_ill <= 1'b0;
        end else if (!stall) begin
            r_pc <= if_pc; r_insn <= if_insn; r_en <= 1'b1;
            r_rs1 <= w_rs1; r_rs2 <= w_rs2; r_rd <= w_rd;
            r_imm <= XLEN'($signed(w_imm));
            r_alu <= w_alu; r_mem <= w_mem; r_we <= w_has_rd && (w_rd != 5'd0);
            r_br <= w_br; r_jal <= w_jal; r_jalr <= w_jalr; r_ill <= w_ill;
        end
    end

    assign id_pc        = r_pc;
    assign id_insn      = r_insn;
    assign id_en        = r_en;
    assign id_rs1_addr  = r_rs1;
    assign id_rs2_addr  = r_rs2;
    assign id_rd_addr   = r_rd;
    assign id_imm       = r_imm;
    assign id_alu_op    = r_alu;
    assign id_mem_op    = r_mem;
    assign id_reg_we    = r_we;
    assign id_is_branch = r_br;
    assign id_is_jal    = r_jal;
    assign id_is_jalr   = r_jalr;
    assign id_illegal   = r_ill;
    assign id_br_taken  = w_br_taken;
    assign id_br_addr   = r_pc + r_imm;
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: expected register contents are queued as
// each instruction is driven and compared one edge later.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        reset, if_en, stall, flush;
    logic [31:0] if_pc, if_insn;
    logic [31:0] id_pc, id_insn, id_imm, id_br_addr;
    logic        id_en, id_reg_we, id_is_branch, id_is_jal, id_is_jalr, id_illegal, id_br_taken;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [3:0]  id_alu_op, id_mem_op;

    always #5 clk = ~clk;

    id_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en),
        .stall(stall), .flush(flush), .id_pc(id_pc), .id_insn(id_insn), .id_en(id_en),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_imm(id_imm), .id_alu_op(id_alu_op), .id_mem_op(id_mem_op), .id_reg_we(id_reg_we),
        .id_is_branch(id_is_branch), .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr),
        .id_illegal(id_illegal), .id_br_taken(id_br_taken), .id_br_addr(id_br_addr)
    );

    typedef struct {
        logic        en;
        logic [31:0] insn, pc, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu, mem;
        logic        we, br, jal, jalr, ill;
    } exp_t;

    exp_t q_exp[$];
    exp_t last;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic en, input logic [31:0] insn, input logic [31:0] pc,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] imm, input logic [3:0] alu, input logic [3:0] mem,
                                input logic we, input logic br, input logic jal, input logic jalr,
                                input logic ill);
        exp_t e;
        e.en = en; e.insn = insn; e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.imm = imm; e.alu = alu; e.mem = mem; e.we = we; e.br = br; e.jal = jal;
        e.jalr = jalr; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t bub();
        return mk(0, 32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic exp_t illeg(input logic [31:0] insn, input logic [31:0] pc);
        return mk(1, insn, pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endfunction

    task automatic compare(input string tag, input exp_t e);
        chk({tag, ".en"},   {31'd0, id_en}, {31'd0, e.en});
        chk({tag, ".insn"}, id_insn, e.insn);
        chk({tag, ".pc"},   id_pc, e.pc);
        chk({tag, ".we"},   {31'd0, id_reg_we}, {31'd0, e.we});
        chk({tag, ".mem"},  {28'd0, id_mem_op}, {28'd0, e.mem});
        chk({tag, ".ctl"},  {29'd0, id_is_branch, id_is_jal, id_is_jalr},
                            {29'd0, e.br, e.jal, e.jalr});
        chk({tag, ".ill"},  {31'd0, id_illegal}, {31'd0, e.ill});
        // illegal encodings only fix the flags above
        if (!e.ill) begin
            chk({tag, ".rs1"}, {27'd0, id_rs1_addr}, {27'd0, e.rs1});
            chk({tag, ".rs2"}, {27'd0, id_rs2_addr}, {27'd0, e.rs2});
            chk({tag, ".rd"},  {27'd0, id_rd_addr},  {27'd0, e.rd});
            chk({tag, ".imm"}, id_imm, e.imm);
            chk({tag, ".alu"}, {28'd0, id_alu_op}, {28'd0, e.alu});
        end
    endtask

    // One cycle: apply inputs, check the redirect for this cycle, clock, check registers.
    task automatic step(input string tag, input logic rst, input logic st, input logic fl,
                        input logic en, input logic [31:0] pc, input logic [31:0] insn,
                        input logic exp_bt, input logic [31:0] exp_ba, input exp_t e);
        exp_t got;
        reset = rst; stall = st; flush = fl; if_en = en; if_pc = pc; if_insn = insn;
        q_exp.push_back(e);
        last = e;
        #1;
        chk({tag, ".br_taken"}, {31'd0, id_br_taken}, {31'd0, exp_bt});
        if (exp_bt) chk({tag, ".br_addr"}, id_br_addr, exp_ba);
        @(posedge clk);
        #1;
        if (q_exp.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: scoreboard empty, got en=%0d, expected an entry", tag, id_en);
        end else begin
            got = q_exp.pop_front();
            compare(tag, got);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; if_en = 1'b1;
        if_pc = 32'd0; if_insn = 32'hFFFF_FFFF;
        last = bub();

        step("rst0", 1, 0, 0, 1, 32'h0, 32'hFFFF_FFFF, 0, 0, bub());
        step("rst1", 1, 0, 0, 1, 32'h0, 32'hFFFF_FFFF, 0, 0, bub());

        step("addi", 0, 0, 0, 1, 32'h10, 32'hFFF0_0293, 0, 0,
             mk(1, 32'hFFF0_0293, 32'h10, 0, 0, 5, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 0, 0));
        step("jal8", 0, 0, 0, 1, 32'h20, 32'h0080_00EF, 0, 0,
             mk(1, 32'h0080_00EF, 32'h20, 0, 0, 1, 32'h8, 0, 0, 1, 0, 1, 0, 0));
        step("squash", 0, 0, 0, 1, 32'h24, 32'hFFF0_0293, 1, 32'h28, bub());
        step("sub", 0, 0, 0, 1, 32'h28, 32'h4020_81B3, 0, 0,
             mk(1, 32'h4020_81B3, 32'h28, 1, 2, 3, 0, 1, 0, 1, 0, 0, 0, 0));
        step("lw", 0, 0, 0, 1, 32'h2C, 32'hFFC1_2383, 0, 0,
             mk(1, 32'hFFC1_2383, 32'h2C, 2, 0, 7, 32'hFFFF_FFFC, 0, 3, 1, 0, 0, 0, 0));
        step("beq", 0, 0, 0, 1, 32'h30, 32'h0020_8863, 0, 0,
             mk(1, 32'h0020_8863, 32'h30, 1, 2, 0, 32'h10, 1, 0, 0, 1, 0, 0, 0));
        step("lui", 0, 0, 0, 1, 32'h34, 32'h1234_5537, 0, 0,
             mk(1, 32'h1234_5537, 32'h34, 0, 0, 10, 32'h1234_5000, 10, 0, 1, 0, 0, 0, 0));
        step("srai", 0, 0, 0, 1, 32'h38, 32'h4032_5213, 0, 0,
             mk(1, 32'h4032_5213, 32'h38, 4, 0, 4, 32'h403, 7, 0, 1, 0, 0, 0, 0));
        step("fence", 0, 0, 0, 1, 32'h3C, 32'h0000_000F, 0, 0,
             mk(1, 32'h0000_000F, 32'h3C, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("noen", 0, 0, 0, 0, 32'h40, 32'h0020_A423, 0, 0, bub());

        step("sw", 0, 0, 0, 1, 32'h40, 32'h0020_A423, 0, 0,
             mk(1, 32'h0020_A423, 32'h40, 1, 2, 0, 32'h8, 0, 8, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            step("sw_hold", 0, 1, 0, 1, 32'h44, 32'hFFF0_0293, 0, 0, last);
        step("stall_flush", 0, 1, 1, 1, 32'h44, 32'hFFF0_0293, 0, 0, bub());

        step("jal_m4", 0, 0, 0, 1, 32'h0, 32'hFFDF_F06F, 0, 0,
             mk(1, 32'hFFDF_F06F, 32'h0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 1, 0, 0));
        step("jal_stall", 0, 1, 0, 1, 32'h4, 32'hFFF0_0293, 0, 0, last);
        step("jal_wrap", 0, 0, 0, 1, 32'h4, 32'hFFF0_0293, 1, 32'hFFFF_FFFC, bub());

        step("jal_f", 0, 0, 0, 1, 32'h20, 32'h0080_00EF, 0, 0,
             mk(1, 32'h0080_00EF, 32'h20, 0, 0, 1, 32'h8, 0, 0, 1, 0, 1, 0, 0));
        step("jal_flush", 0, 0, 1, 1, 32'h24, 32'hFFF0_0293, 0, 0, bub());

        step("b2b_a", 0, 0, 0, 1, 32'h50, 32'h0080_00EF, 0, 0,
             mk(1, 32'h0080_00EF, 32'h50, 0, 0, 1, 32'h8, 0, 0, 1, 0, 1, 0, 0));
        step("b2b_b", 0, 0, 0, 1, 32'h54, 32'h0080_00EF, 1, 32'h58, bub());
        step("b2b_c", 0, 0, 0, 1, 32'h58, 32'h4020_81B3, 0, 0,
             mk(1, 32'h4020_81B3, 32'h58, 1, 2, 3, 0, 1, 0, 1, 0, 0, 0, 0));

        step("ill_opc", 0, 0, 0, 1, 32'h60, 32'h0000_007F, 0, 0, illeg(32'h0000_007F, 32'h60));
        step("ill_f7", 0, 0, 0, 1, 32'h64, 32'h0220_81B3, 0, 0, illeg(32'h0220_81B3, 32'h64));

        step("rst_mid", 1, 1, 0, 1, 32'h68, 32'hFFF0_0293, 0, 0, bub());
        step("post_rst_stall", 0, 1, 0, 1, 32'h70, 32'hFFF0_0293, 0, 0, last);
        step("post_rst_load", 0, 0, 0, 1, 32'h70, 32'hFFF0_0293, 0, 0,
             mk(1, 32'hFFF0_0293, 32'h70, 0, 0, 5, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
